lsu_mem_stage: RTL

Load/store unit directly downstream of the execute-stage ALU. It consumes the ALU's computed effective address, the instruction's funct3 and the rs2 store value. It runs one data-memory transaction over a simple req/ready bus and returns aligned, extended load data to write-back. The control FSM holds the core in the memory stage via busy until done pulses.

---
 rtl/lsu_mem_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage sitting behind the execute-stage ALU.
// Takes the effective address, funct3 and rs2 value, validates the access,
// runs one transaction on a req/ready data bus, and returns aligned,
// sign/zero-extended load data to write-back.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start, is_load, is_store       access launch and op kind (sampled in IDLE)
//   funct3, address, store_data    width/sign code, effective address, rs2 value
//   mem_req/we/wstrb/addr/wdata    data bus request side
//   mem_rdata, mem_ready           data bus response side
//   load_data                      extracted load result
//   done, busy                     completion pulse, stage-occupied indication
//   misaligned, access_fault       status flags, valid with done
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        access_fault
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StReq, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     sdata_q, sdata_d;
    logic            is_load_q, is_load_d;
    logic            is_store_q, is_store_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            misaligned_q, misaligned_d;
    logic            fault_q, fault_d;

    logic            op_illegal;
    logic            addr_misaligned;
    logic [3:0]      strb;
    logic [31:0]     wdata;
    logic [31:0]     byte_word;
    logic [15:0]     half_sel;
    logic [31:0]     extracted;

    always_comb begin
        if (is_load_q && is_store_q) begin
            op_illegal = 1'b1;
        end else if (is_load_q) begin
            op_illegal = (funct3_q == 3'd3) || (funct3_q == 3'd6) || (funct3_q == 3'd7);
        end else begin
            op_illegal = (funct3_q > 3'd2);
        end
    end

    // funct3[1:0] gives width for both signed and unsigned variants.
    assign addr_misaligned = ((funct3_q[1:0] == 2'd1) && addr_q[0]) ||
                             ((funct3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'b00));

    always_comb begin
        strb  = 4'b0000;
        wdata = sdata_q;
        unique case (funct3_q[1:0])
            2'd0: begin
                strb  = 4'b0001 << addr_q[1:0];
                wdata = {4{sdata_q[7:0]}};
            end
            2'd1: begin
                strb  = 4'b0011 << addr_q[1:0];
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = sdata_q;
            end
        endcase
    end

    assign byte_word = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        unique case (funct3_q)
            3'd0:    extracted = {{24{byte_word[7]}}, byte_word[7:0]};
            3'd4:    extracted = {24'd0, byte_word[7:0]};
            3'd1:    extracted = {{16{half_sel[15]}}, half_sel};
            3'd5:    extracted = {16'd0, half_sel};
            default: extracted = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        sdata_d      = sdata_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;
        case (state_q)
            StIdle: begin
                if (start && (is_load || is_store)) begin
                    addr_d       = address;
                    funct3_d     = funct3;
                    sdata_d      = store_data;
                    is_load_d    = is_load;
                    is_store_d   = is_store;
                    cnt_d        = '0;
                    load_data_d  = '0;
                    misaligned_d = 1'b0;
                    fault_d      = 1'b0;
                    state_d      = StCheck;
                end
            end
            StCheck: begin
                if (op_illegal) begin
                    fault_d = 1'b1;
                    state_d = StDone;
                end else if (addr_misaligned) begin
                    misaligned_d = 1'b1;
                    state_d      = StDone;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    if (is_load_q) begin
                        load_data_d = extracted;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    fault_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            funct3_q     <= '0;
            sdata_q      <= '0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            sdata_q      <= sdata_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    // Bus outputs are decoded from registered state only, so they cannot
    // change while a request waits for ready.
    always_comb begin
        mem_req   = (state_q == StReq);
        mem_we    = mem_req && is_store_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wstrb = mem_we ? strb : 4'b0000;
        mem_wdata = mem_we ? wdata : 32'd0;
    end

    assign load_data    = load_data_q;
    assign done         = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign misaligned   = misaligned_q;
    assign access_fault = fault_q;

endmodule
